// File: rtl/sdram_wr_pkg.sv
// Shared definitions for the SDRAM write-side scheduler.
//   state_t       : scheduler FSM encodings
//   DEF_BURST_LEN : default maximum burst length / buffer depth
//   DEF_ADDR_W    : default SDRAM word-address width
//   LEN_W         : width of the wr_len burst-length field
package sdram_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_REQ  = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_ADDR_W    = 24;
    localparam int LEN_W         = 9;

endpackage

// File: rtl/sdram_wr_burst_buf.sv
// Circular burst buffer: BURST_LEN x 16 register file, one synchronous write
// port, one asynchronous read port, plus write/read pointers and fill count.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en      : store wr_word at the write pointer
//   rd_en      : pop the head word (advance read pointer)
//   rd_word    : current head word, combinational
//   count      : number of words held, 0..BURST_LEN
module sdram_wr_burst_buf
    import sdram_wr_pkg::*;
#(
    parameter  int BURST_LEN = DEF_BURST_LEN,
    localparam int PTR_W     = $clog2(BURST_LEN),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [15:0]      wr_word,
    input  logic             rd_en,
    output logic [15:0]      rd_word,
    output logic [CNT_W-1:0] count
);

    logic [15:0]      mem [BURST_LEN];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage is data, so it carries no reset; stale contents are never read
    // because count gates every pop.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_word;
        end
    end

    // Pointers are power-of-two wide, so they wrap around the ring naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_word = mem[rptr];

endmodule

// File: rtl/sdram_wr_sched.sv
// Write-side scheduler between the clock-crossing FIFO read side and the
// SDRAM controller write port, all in the SDRAM clock domain.
//   sdram_clk, rst_n      : clock, asynchronous active-low reset
//   sdram_init_done       : controller ready; sampled only in IDLE
//   fifo_ren/rdata/rempty : FIFO read side, data valid the cycle after ren
//   flush                 : pulse forcing a partial burst if words are held
//   wr_req/ack/addr/len   : burst request handshake
//   wr_data_req/wr_data   : per-word transfer, wr_data is the buffer head
//   wr_done               : burst finished at the SDRAM
//   busy, wrap, burst_cnt : status
module sdram_wr_sched
    import sdram_wr_pkg::*;
#(
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 2 ** 24,
    parameter int TIMEOUT      = 1024
) (
    input  logic              sdram_clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    output logic              fifo_ren,
    input  logic [15:0]       fifo_rdata,
    input  logic              fifo_rempty,
    input  logic              flush,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LEN_W-1:0]  wr_len,
    input  logic              wr_data_req,
    output logic [15:0]       wr_data,
    input  logic              wr_done,
    output logic              busy,
    output logic              wrap,
    output logic [15:0]       burst_cnt
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W:0]    FULL_X   = (CNT_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   END_ADDR = (ADDR_W + 1)'(BASE_ADDR + REGION_WORDS);
    localparam logic [31:0]       TO_LIM   = 32'(TIMEOUT);

    state_t             state;
    state_t             state_nxt;
    logic               vld_p1;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occupancy;
    logic               flush_pend;
    logic               done_pend;
    logic [31:0]        to_cnt;
    logic               to_hit;
    logic               want_req;
    logic [LEN_W-1:0]   xfer_cnt;
    logic               accept;
    logic               xfer_last;
    logic [ADDR_W:0]    room;
    logic [LEN_W-1:0]   len_nxt;
    logic [ADDR_W:0]    addr_sum;

    sdram_wr_burst_buf #(
        .BURST_LEN (BURST_LEN)
    ) u_buf (
        .clk     (sdram_clk),
        .rst_n   (rst_n),
        .wr_en   (vld_p1),
        .wr_word (fifo_rdata),
        .rd_en   (accept),
        .rd_word (wr_data),
        .count   (count)
    );

    // Reads in flight count against free space so the buffer never overruns.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
    assign to_hit    = (TIMEOUT != 0) && (to_cnt == TO_LIM) && (count != '0);
    assign want_req  = (count != '0) && ((count == FULL) || to_hit || flush_pend);

    // A burst may start in the wr_ack cycle itself, and requests past wr_len
    // are ignored.
    assign accept    = wr_data_req && (xfer_cnt < wr_len) &&
                       ((state == ST_XFER) || ((state == ST_REQ) && wr_ack));
    assign xfer_last = (xfer_cnt + 1'b1) == wr_len;

    // Clip the burst at the end of the region; the residue stays buffered.
    assign room     = END_ADDR - {1'b0, wr_addr};
    assign len_nxt  = (room < (ADDR_W + 1)'(count)) ? LEN_W'(room) : LEN_W'(count);
    assign addr_sum = {1'b0, wr_addr} + (ADDR_W + 1)'(wr_len);

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_ren  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sdram_init_done) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                fifo_ren = !fifo_rempty && (occupancy < FULL_X) && !want_req;
                // Hold off until the in-flight word has landed.
                if (want_req && !vld_p1) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_ack) begin
                    state_nxt = (accept && xfer_last) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept && xfer_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wr_done || done_pend) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // p0 -> p1: fifo_ren issued in p0, fifo_rdata captured into the buffer in p1
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            wr_req     <= 1'b0;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            flush_pend <= 1'b0;
            done_pend  <= 1'b0;
            to_cnt     <= '0;
            xfer_cnt   <= '0;
            wr_len     <= '0;
            wr_addr    <= BASE_A;
            burst_cnt  <= '0;
        end else begin
            vld_p1 <= fifo_ren;
            wr_req <= (state_nxt == ST_REQ);
            busy   <= (state_nxt == ST_REQ) || (state_nxt == ST_XFER) ||
                      (state_nxt == ST_DONE);
            wrap   <= 1'b0;

            // An empty-buffer flush is dropped rather than remembered.
            if (state_nxt != ST_FILL) begin
                flush_pend <= 1'b0;
            end else if ((state == ST_FILL) && flush && (count != '0)) begin
                flush_pend <= 1'b1;
            end

            if ((state_nxt != ST_FILL) || vld_p1) begin
                to_cnt <= '0;
            end else if ((state == ST_FILL) && (count != '0) && fifo_rempty && !to_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if ((state == ST_FILL) && (state_nxt == ST_REQ)) begin
                wr_len   <= len_nxt;
                xfer_cnt <= '0;
            end else if (accept) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end

            // An early wr_done is remembered until the last word has gone.
            if (state == ST_DONE) begin
                done_pend <= 1'b0;
            end else if (wr_done && ((state == ST_REQ) || (state == ST_XFER))) begin
                done_pend <= 1'b1;
            end

            if ((state == ST_DONE) && (state_nxt == ST_FILL)) begin
                burst_cnt <= burst_cnt + 1'b1;
                if (addr_sum == END_ADDR) begin
                    wr_addr <= BASE_A;
                    wrap    <= 1'b1;
                end else begin
                    wr_addr <= addr_sum[ADDR_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_wr_sched.sv
// Directed self-checking bench for sdram_wr_sched with a small region
// (32 words) and short timeout (20 cycles) so wrap, clipping and timeout
// bursts are reached quickly.
module tb_sdram_wr_sched;

    localparam int BL     = 16;
    localparam int AW     = 24;
    localparam int REGION = 32;
    localparam int TO     = 20;

    logic          sdram_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sdram_init_done = 1'b0;
    logic          fifo_ren;
    logic [15:0]   fifo_rdata = '0;
    logic          fifo_rempty;
    logic          flush = 1'b0;
    logic          wr_req;
    logic          wr_ack = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_len;
    logic          wr_data_req = 1'b0;
    logic [15:0]   wr_data;
    logic          wr_done = 1'b0;
    logic          busy;
    logic          wrap;
    logic [15:0]   burst_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_idx   = 0;
    int src_avail = 0;
    int exp_idx  = 0;
    int bcnt     = 0;

    sdram_wr_sched #(
        .BURST_LEN    (BL),
        .ADDR_W       (AW),
        .BASE_ADDR    (0),
        .REGION_WORDS (REGION),
        .TIMEOUT      (TO)
    ) dut (
        .sdram_clk       (sdram_clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .fifo_ren        (fifo_ren),
        .fifo_rdata      (fifo_rdata),
        .fifo_rempty     (fifo_rempty),
        .flush           (flush),
        .wr_req          (wr_req),
        .wr_ack          (wr_ack),
        .wr_addr         (wr_addr),
        .wr_len          (wr_len),
        .wr_data_req     (wr_data_req),
        .wr_data         (wr_data),
        .wr_done         (wr_done),
        .busy            (busy),
        .wrap            (wrap),
        .burst_cnt       (burst_cnt)
    );

    always #5 sdram_clk = ~sdram_clk;

    function automatic logic [15:0] word_of(input int i);
        return 16'(i);
    endfunction

    // FIFO source: word i is i; src_avail words have been written so far.
    assign fifo_rempty = (rd_idx >= src_avail);
    always @(posedge sdram_clk) begin
        if (fifo_ren) begin
            fifo_rdata <= word_of(rd_idx);
            rd_idx     <= rd_idx + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk_eq("rst_wr_req",    32'(wr_req),    0);
        chk_eq("rst_busy",      32'(busy),      0);
        chk_eq("rst_wrap",      32'(wrap),      0);
        chk_eq("rst_fifo_ren",  32'(fifo_ren),  0);
        chk_eq("rst_wr_addr",   32'(wr_addr),   0);
        chk_eq("rst_wr_len",    32'(wr_len),    0);
        chk_eq("rst_burst_cnt", 32'(burst_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge sdram_clk);
        rst_n = 1'b0; flush = 1'b0; wr_ack = 1'b0; wr_data_req = 1'b0; wr_done = 1'b0;
        #1;
        src_avail = rd_idx;
        chk_reset_vals();
        repeat (2) @(negedge sdram_clk);
        rst_n   = 1'b1;
        exp_idx = rd_idx;
        bcnt    = 0;
    endtask

    // Controller model for one burst: waits for wr_req, checks address and
    // length, acks after ack_dly cycles with the first word in the ack cycle,
    // streams exp_len words (alternate-cycle gaps when gap), then signals
    // wr_done done_dly cycles later (or early, during XFER, when early_done).
    task automatic do_burst(input int exp_addr, input int exp_len, input int max_wait,
                            input int ack_dly, input bit gap, input int done_dly,
                            input bit early_done, input bit exp_wrap);
        int  n;
        int  words;
        int  rd0;
        bit  ph;
        n = 0;
        while (!wr_req && n < max_wait) begin
            @(negedge sdram_clk);
            n++;
        end
        chk_eq("wr_req_rise", 32'(wr_req), 1);
        if (!wr_req) return;
        chk_eq("wr_addr", 32'(wr_addr), 32'(exp_addr));
        chk_eq("wr_len",  32'(wr_len),  32'(exp_len));
        rd0 = rd_idx;
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge sdram_clk);
            chk_eq("req_hold",   32'(wr_req),   1);
            chk_eq("addr_hold",  32'(wr_addr),  32'(exp_addr));
            chk_eq("len_hold",   32'(wr_len),   32'(exp_len));
            chk_eq("no_rd_req",  32'(fifo_ren), 0);
        end
        wr_ack = 1'b1;
        wr_data_req = 1'b1;
        chk_eq("wr_data", 32'(wr_data), 32'(word_of(exp_idx)));
        exp_idx++;
        words = 1;
        ph = 1'b0;
        @(negedge sdram_clk);
        wr_ack = 1'b0;
        chk_eq("req_drop", 32'(wr_req), 0);
        if (early_done) wr_done = 1'b1;
        while (words < exp_len) begin
            ph = gap ? ~ph : 1'b1;
            wr_data_req = ph;
            if (ph) begin
                chk_eq("wr_data", 32'(wr_data), 32'(word_of(exp_idx)));
                exp_idx++;
                words++;
            end else begin
                chk_eq("addr_xfer", 32'(wr_addr), 32'(exp_addr));
            end
            @(negedge sdram_clk);
            wr_done = 1'b0;
        end
        wr_done = 1'b0;
        // In DONE now; wr_data_req stays high one more cycle and must be ignored.
        chk_eq("busy_done", 32'(busy), 1);
        for (int k = 0; k < done_dly; k++) begin
            chk_eq("no_rd_done", 32'(fifo_ren), 0);
            @(negedge sdram_clk);
            wr_data_req = 1'b0;
        end
        wr_data_req = 1'b0;
        if (!early_done) wr_done = 1'b1;
        @(negedge sdram_clk);
        wr_done = 1'b0;
        bcnt++;
        chk_eq("no_fifo_rd_burst", 32'(rd_idx),    32'(rd0));
        chk_eq("burst_cnt",        32'(burst_cnt), 32'(bcnt));
        chk_eq("wrap",             32'(wrap),      32'(exp_wrap));
    endtask

    initial begin
        int n;

        // Reset values, IDLE holds off until init_done
        do_reset();
        src_avail = rd_idx + 40;
        repeat (5) @(negedge sdram_clk);
        chk_eq("idle_no_read", 32'(fifo_ren), 0);
        chk_eq("idle_busy",    32'(busy),     0);
        sdram_init_done = 1'b1;

        // Full bursts, wrap at region end, then flush of the last 8
        do_burst(0,  16, 200, 0, 1'b0, 0, 1'b0, 1'b0);
        do_burst(16, 16, 200, 0, 1'b0, 0, 1'b0, 1'b1);
        repeat (12) @(negedge sdram_clk);
        flush = 1'b1;
        @(negedge sdram_clk);
        flush = 1'b0;
        do_burst(0, 8, 8, 0, 1'b0, 0, 1'b0, 1'b0);

        // Timeout burst, then clipped burst at region end with residue
        do_reset();
        src_avail = rd_idx + 5;
        repeat (TO) @(negedge sdram_clk);
        chk_eq("no_early_timeout", 32'(wr_req), 0);
        do_burst(0, 5, 40, 0, 1'b0, 0, 1'b0, 1'b0);
        src_avail = src_avail + 32;
        do_burst(5,  16, 200, 0, 1'b0, 0, 1'b0, 1'b0);
        do_burst(21, 11, 200, 0, 1'b0, 0, 1'b0, 1'b1);
        do_burst(0,  5,  60,  0, 1'b0, 0, 1'b0, 1'b0);

        // Flush with empty buffer is dropped; flush with 3 words bursts
        do_reset();
        repeat (3) @(negedge sdram_clk);
        flush = 1'b1;
        @(negedge sdram_clk);
        flush = 1'b0;
        repeat (30) @(negedge sdram_clk);
        chk_eq("empty_flush_no_req", 32'(wr_req), 0);
        src_avail = rd_idx + 3;
        repeat (6) @(negedge sdram_clk);
        flush = 1'b1;
        @(negedge sdram_clk);
        flush = 1'b0;
        do_burst(0, 3, 8, 0, 1'b0, 0, 1'b0, 1'b0);

        // Slow controller, gapped data, late and early wr_done
        do_reset();
        src_avail = rd_idx + 48;
        do_burst(0,  16, 200, 7, 1'b1, 4, 1'b0, 1'b0);
        do_burst(16, 16, 200, 0, 1'b0, 0, 1'b1, 1'b1);

        // Reset in XFER after 6 of 16 words
        do_reset();
        src_avail = rd_idx + 32;
        n = 0;
        while (!wr_req && n < 200) begin
            @(negedge sdram_clk);
            n++;
        end
        chk_eq("abort_req",  32'(wr_req),  1);
        chk_eq("abort_addr", 32'(wr_addr), 0);
        wr_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_data_req = 1'b1;
            chk_eq("abort_data", 32'(wr_data), 32'(word_of(exp_idx)));
            exp_idx++;
            @(negedge sdram_clk);
            wr_ack = 1'b0;
        end
        chk_eq("abort_busy_pre", 32'(busy), 1);
        wr_data_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge sdram_clk);
        rst_n   = 1'b1;
        exp_idx = rd_idx;
        bcnt    = 0;
        do_burst(0, 16, 200, 0, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge sdram_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_wr_sched.md
# sdram_wr_sched

Write-side scheduler between the USB-to-SDRAM clock-crossing FIFO and the SDRAM controller's write port, running entirely in the SDRAM clock domain. It drains 16-bit words from the FIFO read side into a local burst buffer. It then issues addressed write bursts to the SDRAM controller, either a full burst or a partial burst on timeout or flush. A linear write address cycles through a fixed SDRAM region.

## Interface
- BURST_LEN, 16: max words per SDRAM write burst; power of two, 2..256; also the buffer depth
- ADDR_W, 24: SDRAM word-address width
- BASE_ADDR, 0: first word address of the write region
- REGION_WORDS, 2^24: region size in words; multiple of BURST_LEN
- TIMEOUT, 1024: idle-FIFO cycles before a partial burst is flushed; 0 disables the timeout
- sdram_clk  in  1  133 MHz clock
- rst_n  in  1  asynchronous active-low reset
- sdram_init_done  in  1  SDRAM controller initialised
- fifo_ren  out  1  FIFO read enable
- fifo_rdata  in  16  FIFO data, valid the cycle after fifo_ren
- fifo_rempty  in  1  FIFO empty
- flush  in  1  one-cycle pulse; forces a partial burst out
- wr_req  out  1  burst request, level, held until wr_ack
- wr_ack  in  1  controller accepted the request, one-cycle pulse
- wr_addr  out  ADDR_W  burst start address, stable while wr_req is high and through the burst
- wr_len  out  9  burst length in words, 1..BURST_LEN
- wr_data_req  in  1  controller consumes one word this cycle
- wr_data  out  16  current buffer head word
- wr_done  in  1  burst finished at the SDRAM, one-cycle pulse
- busy  out  1  high in any state except IDLE/FILL
- wrap  out  1  one-cycle pulse when the address returns to BASE_ADDR
- burst_cnt  out  16  completed bursts, wraps modulo 2^16

## Operation
- States:
  - IDLE: leave when sdram_init_done is high.
  - FILL: read FIFO words into the buffer.
  - REQ: assert wr_req; go to XFER on wr_ack.
  - XFER: stream words on wr_data_req.
  - DONE: wait for wr_done, update address and counters, return to FILL.
- FILL:
  - fifo_ren = !fifo_rempty && (count + inflight) < BURST_LEN.
  - The word is captured into buf[wptr] one cycle later; count and wptr increment.
- FILL → REQ triggers (the in-flight read is captured first):
  - count == BURST_LEN;
  - timeout counter reaches TIMEOUT with count > 0;
  - flush seen with count > 0. Flush is latched; a flush with count == 0 is dropped.
- Timeout counter:
  - Counts FILL cycles while count > 0 and fifo_rempty is high.
  - Clears on every capture and on leaving FILL.
- Burst length and address:
  - wr_len = min(count, BASE_ADDR + REGION_WORDS − wr_addr), latched on entry to REQ.
  - A clipped burst leaves its residue in the buffer.
  - Buffer is circular with BURST_LEN entries; wptr/rptr are log2(BURST_LEN) bits, count is log2(BURST_LEN)+1 bits.
- XFER:
  - wr_data = buf[rptr], combinational.
  - Each wr_data_req cycle: rptr++, count−−, xfer_cnt++.
  - wr_data_req beyond wr_len words is ignored.
  - After wr_len words → DONE.
- DONE, on wr_done:
  - wr_addr += wr_len; if the result equals BASE_ADDR + REGION_WORDS, wr_addr = BASE_ADDR and wrap pulses.
  - burst_cnt++; → FILL.
  - wr_done arriving in XFER is held and honoured in DONE.
- fifo_ren is low outside FILL; no FIFO reads happen during REQ/XFER/DONE.
- sdram_init_done is sampled only in IDLE.

## Timing
- Reset values:
  - state IDLE, wr_addr = BASE_ADDR.
  - fifo_ren, wr_req, wrap, busy = 0.
  - wr_len, burst_cnt, count, pointers = 0.
  - wr_data = buf[0]; buffer contents are don't-care.
- Reset mid-burst aborts immediately; buffered words are discarded.
- All outputs are registered except fifo_ren and wr_data.
- Latency:
  - First FIFO word to wr_req for a full burst: BURST_LEN + 2 cycles with a never-empty FIFO.
  - wr_ack → first accepted wr_data_req: the same cycle is allowed.
- Data order:
  - wr_data order equals FIFO order; no gaps or duplicates across partial, clipped or wrapped bursts.

## Structure
- Shared package/header sdram_wr_pkg:
  - state encodings (IDLE, FILL, REQ, XFER, DONE);
  - defaults for BURST_LEN and ADDR_W;
  - wr_len width.
- One sub-module, sdram_wr_burst_buf: BURST_LEN×16 register file with one synchronous write port and one asynchronous read port, plus the wptr/rptr/count logic.

## Test plan
- Never-empty FIFO, 32 words 0x0000..0x001F, wr_ack and wr_data_req immediate → two bursts at addresses 0 and 16, wr_len 16, data in order, burst_cnt = 2.
- 5 words then FIFO empty for TIMEOUT cycles → one burst with wr_len 5 at address 0; next burst starts at address 5.
- 3 words then a flush pulse; also a flush with an empty buffer → one burst with wr_len 3; the empty-buffer flush produces no wr_req.
- REGION_WORDS = 32, 40 words streamed → bursts of 16 @0, 16 @16, 8 @0; wrap pulses once after the second burst's wr_done.
- wr_ack delayed 7 cycles, wr_data_req gapped, wr_done 4 cycles late → wr_req/wr_addr/wr_len stay stable; no FIFO reads until back in FILL.
- rst_n asserted in XFER after 6 of 16 words → all outputs return to reset values asynchronously; after release, the first burst starts at BASE_ADDR with new data only.
